// File: rtl/regfile_scoreboard.sv
// Parametrised register file: async reads with same-cycle write bypass, sync writes, plus a pending-write scoreboard.
// Reads are 0-cycle (bypass), issue-to-busy is 1 cycle; there is no backpressure and every strobe is taken the cycle it is shown.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        Rd,
    input  logic                 WriteEn,
    input  logic [XLEN-1:0]      WriteData,
    input  logic                 IssueEn,
    input  logic [AW-1:0]        IssueRd,
    input  logic                 Flush,
    input  logic [NRD*AW-1:0]    Rs,
    output logic [NRD*XLEN-1:0]  ReadData,
    output logic [NRD-1:0]       ReadBusy,
    output logic [CW-1:0]        NumBusy
);

    localparam logic [AW:0] LP_NREGS = (AW+1)'(NREGS);

    // An index names a real, writable register: in range and not the hardwired zero.
    function automatic logic idx_ok(input logic [AW-1:0] idx);
        return ({1'b0, idx} < LP_NREGS) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    logic [XLEN-1:0]  r_bank [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [CW-1:0]    r_num_busy;

    logic             w_wr_ok;
    logic             w_iss_ok;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic             w_inc;
    logic             w_dec;

    assign w_wr_ok  = WriteEn && idx_ok(Rd);
    assign w_iss_ok = IssueEn && idx_ok(IssueRd);

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_set[i] = w_iss_ok && (IssueRd == AW'(i));
            w_clr[i] = w_wr_ok && (Rd == AW'(i));
        end
    end

    // Set beats clear on the same index, so a retire never decrements a register being re-issued.
    assign w_inc = |(w_set & ~r_pend);
    assign w_dec = |(w_clr & r_pend & ~w_set);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_bank[Rd] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend     <= '0;
            r_num_busy <= '0;
        end else if (Flush) begin
            r_pend     <= '0;
            r_num_busy <= '0;
        end else begin
            r_pend     <= (r_pend & ~w_clr) | w_set;
            r_num_busy <= r_num_busy + CW'(w_inc) - CW'(w_dec);
        end
    end

    assign NumBusy = r_num_busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_rs;
        logic          w_ok;
        logic          w_hit;

        assign w_rs  = Rs[k*AW +: AW];
        assign w_ok  = idx_ok(w_rs);
        assign w_hit = w_wr_ok && (Rd == w_rs);

        // A retiring write both forwards its data and hides the pending flag it is about to clear.
        assign ReadData[k*XLEN +: XLEN] = !w_ok ? '0 : (w_hit ? WriteData : r_bank[w_rs]);
        assign ReadBusy[k]              = w_ok && r_pend[w_rs] && !w_hit;
    end

endmodule
